// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator controller: command codes,
// FSM state encoding and default datapath sizes.
package rpn_pkg;

    localparam int W_DEF     = 8;
    localparam int AW_DEF    = 3;
    localparam int DEPTH_DEF = 8;

    localparam logic [1:0] CMD_PUSH = 2'b00;
    localparam logic [1:0] CMD_ADD  = 2'b01;
    localparam logic [1:0] CMD_SUB  = 2'b10;
    localparam logic [1:0] CMD_MUL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_WR  = 3'd1,
        ST_RD_B     = 3'd2,
        ST_RD_A     = 3'd3,
        ST_EXEC     = 3'd4,
        ST_WAIT_ALU = 3'd5,
        ST_WB       = 3'd6
    } state_t;

    // True when the command only needs the incoming operand (no stack reads).
    function automatic logic cmd_is_push(input logic [1:0] cmd);
        return (cmd == CMD_PUSH);
    endfunction

endpackage

// File: rtl/rpn_key_sync.sv
// Synchronises an active-low push button into the clock domain and emits a
// single-cycle pulse on each press (synchronised high->low transition).
module rpn_key_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic key_n,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic fall_r;

    // Two-flop synchronizer, edge-history flop and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
            fall_r <= 1'b0;
        end else if (srst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
            fall_r <= 1'b0;
        end else begin
            meta_r <= key_n;
            sync_r <= meta_r;
            prev_r <= sync_r;
            fall_r <= prev_r & ~sync_r;
        end
    end

    assign fall = fall_r;

endmodule

// File: rtl/rpn_ctrl.sv
// Sequencing controller for the RPN calculator: turns Enter presses into
// stack-RAM reads/writes and ALU transactions, and owns the stack pointer,
// the cached top-of-stack and the sticky error flags.
module rpn_ctrl
    import rpn_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    input  logic          enter_n,
    input  logic [1:0]    sw_cmd,
    input  logic [W-1:0]  sw_data,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [W-1:0]  mem_rdata,
    output logic [1:0]    alu_op,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic          alu_start,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_done,
    output logic [W-1:0]  top,
    output logic [AW:0]   depth,
    output logic          busy,
    output logic          err_underflow,
    output logic          err_overflow
);

    logic accept_s;

    state_t        state_r,      state_nxt_s;
    logic [AW:0]   depth_r,      depth_nxt_s;
    logic [W-1:0]  top_r,        top_nxt_s;
    logic [1:0]    cmd_r,        cmd_nxt_s;
    logic [W-1:0]  data_r,       data_nxt_s;
    logic [W-1:0]  res_r,        res_nxt_s;
    logic [W-1:0]  alu_a_r,      alu_a_nxt_s;
    logic [W-1:0]  alu_b_r,      alu_b_nxt_s;
    logic          alu_start_r,  alu_start_nxt_s;
    logic          err_uf_r,     err_uf_nxt_s;
    logic          err_of_r,     err_of_nxt_s;
    logic          mem_we_r,     mem_we_nxt_s;
    logic [AW-1:0] mem_addr_r,   mem_addr_nxt_s;
    logic [W-1:0]  mem_wdata_r,  mem_wdata_nxt_s;

    logic [AW-1:0] addr_m1_s;
    logic [AW-1:0] addr_m2_s;

    rpn_key_sync u_enter_sync (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .srst  (1'b0),
        .key_n (enter_n),
        .fall  (accept_s)
    );

    // Addresses of the top and second entries, truncated to the RAM width.
    always_comb begin
        addr_m1_s = AW'(depth_r - (AW+1)'(1));
        addr_m2_s = AW'(depth_r - (AW+1)'(2));
    end

    // Next-state and next-output logic; RAM/ALU strobes are computed one
    // cycle ahead so they can be driven straight from flops.
    always_comb begin
        state_nxt_s     = state_r;
        depth_nxt_s     = depth_r;
        top_nxt_s       = top_r;
        cmd_nxt_s       = cmd_r;
        data_nxt_s      = data_r;
        res_nxt_s       = res_r;
        alu_a_nxt_s     = alu_a_r;
        alu_b_nxt_s     = alu_b_r;
        alu_start_nxt_s = 1'b0;
        err_uf_nxt_s    = err_uf_r;
        err_of_nxt_s    = err_of_r;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = {AW{1'b0}};
        mem_wdata_nxt_s = {W{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cmd_nxt_s    = sw_cmd;
                    data_nxt_s   = sw_data;
                    err_uf_nxt_s = 1'b0;
                    err_of_nxt_s = 1'b0;
                    if (cmd_is_push(sw_cmd)) begin
                        if (depth_r == (AW+1)'(DEPTH)) begin
                            err_of_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s     = ST_PUSH_WR;
                            mem_we_nxt_s    = 1'b1;
                            mem_addr_nxt_s  = depth_r[AW-1:0];
                            mem_wdata_nxt_s = sw_data;
                        end
                    end else begin
                        if (depth_r < (AW+1)'(2)) begin
                            err_uf_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s    = ST_RD_B;
                            mem_addr_nxt_s = addr_m1_s;
                        end
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PUSH_WR: begin
                depth_nxt_s = depth_r + (AW+1)'(1);
                top_nxt_s   = data_r;
                state_nxt_s = ST_IDLE;
            end
            ST_RD_B: begin
                mem_addr_nxt_s = addr_m2_s;
                state_nxt_s    = ST_RD_A;
            end
            ST_RD_A: begin
                // RAM now returns the entry addressed during RD_B (the top).
                alu_b_nxt_s = mem_rdata;
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a_nxt_s     = mem_rdata;
                alu_start_nxt_s = 1'b1;
                state_nxt_s     = ST_WAIT_ALU;
            end
            ST_WAIT_ALU: begin
                if (alu_done) begin
                    res_nxt_s       = alu_result;
                    mem_we_nxt_s    = 1'b1;
                    mem_addr_nxt_s  = addr_m2_s;
                    mem_wdata_nxt_s = alu_result;
                    state_nxt_s     = ST_WB;
                end else begin
                    state_nxt_s = ST_WAIT_ALU;
                end
            end
            ST_WB: begin
                depth_nxt_s = depth_r - (AW+1)'(1);
                top_nxt_s   = res_r;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, stack bookkeeping and registered output flops.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            depth_r     <= {(AW+1){1'b0}};
            top_r       <= {W{1'b0}};
            cmd_r       <= 2'b00;
            data_r      <= {W{1'b0}};
            res_r       <= {W{1'b0}};
            alu_a_r     <= {W{1'b0}};
            alu_b_r     <= {W{1'b0}};
            alu_start_r <= 1'b0;
            err_uf_r    <= 1'b0;
            err_of_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            depth_r     <= depth_nxt_s;
            top_r       <= top_nxt_s;
            cmd_r       <= cmd_nxt_s;
            data_r      <= data_nxt_s;
            res_r       <= res_nxt_s;
            alu_a_r     <= alu_a_nxt_s;
            alu_b_r     <= alu_b_nxt_s;
            alu_start_r <= alu_start_nxt_s;
            err_uf_r    <= err_uf_nxt_s;
            err_of_r    <= err_of_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
        end
    end

    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_we        = mem_we_r;
    assign alu_op        = cmd_r;
    assign alu_a         = alu_a_r;
    assign alu_b         = alu_b_r;
    assign alu_start     = alu_start_r;
    assign top           = top_r;
    assign depth         = depth_r;
    assign busy          = (state_r != ST_IDLE);
    assign err_underflow = err_uf_r;
    assign err_overflow  = err_of_r;

endmodule

// File: tb/tb_rpn_ctrl.sv
// Directed self-checking bench for rpn_ctrl with a behavioural stack RAM
// and a fixed-latency ALU model.
module tb_rpn_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b1;
    logic       enter_n  = 1'b1;
    logic [1:0] sw_cmd   = 2'b00;
    logic [7:0] sw_data  = 8'h00;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata = 8'h00;
    logic [1:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_start;
    logic [7:0] alu_result = 8'h00;
    logic       alu_done   = 1'b0;
    logic [7:0] top;
    logic [3:0] depth;
    logic       busy;
    logic       err_underflow;
    logic       err_overflow;

    int checks = 0;
    int errors = 0;

    rpn_ctrl dut (
        .CLOCK_50      (CLOCK_50),
        .rst_n         (rst_n),
        .enter_n       (enter_n),
        .sw_cmd        (sw_cmd),
        .sw_data       (sw_data),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_start     (alu_start),
        .alu_result    (alu_result),
        .alu_done      (alu_done),
        .top           (top),
        .depth         (depth),
        .busy          (busy),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Stack RAM with one-cycle read latency.
    logic [7:0] ram [0:7];
    always @(posedge CLOCK_50) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ALU model: result appears alu_lat cycles after the start pulse.
    int         alu_lat = 3;
    int         alu_cnt = 0;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b;
    logic [15:0] m_prod;
    always @(posedge CLOCK_50) begin
        alu_done <= 1'b0;
        if (alu_start) begin
            alu_cnt <= alu_lat;
            m_op    <= alu_op;
            m_a     <= alu_a;
            m_b     <= alu_b;
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) begin
                alu_done <= 1'b1;
                m_prod = 16'(m_a) * 16'(m_b);
                case (m_op)
                    2'b01:   alu_result <= m_a + m_b;
                    2'b10:   alu_result <= m_a - m_b;
                    2'b11:   alu_result <= m_prod[7:0];
                    default: alu_result <= 8'h00;
                endcase
            end
        end
    end

    // Activity monitor sampled away from the active edge.
    int         n_writes = 0;
    int         n_starts = 0;
    logic [2:0] last_waddr = 3'd0;
    logic [7:0] last_wdata = 8'h00;
    logic [7:0] st_a = 8'h00, st_b = 8'h00;
    logic [1:0] st_op = 2'b00;
    always @(negedge CLOCK_50) begin
        if (mem_we) begin
            n_writes++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (alu_start) begin
            n_starts++;
            st_a  = alu_a;
            st_b  = alu_b;
            st_op = alu_op;
        end
    end

    task automatic do_reset();
        @(negedge CLOCK_50);
        rst_n = 1'b0;
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
        end
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic wait_start(input int s0);
        int n = 0;
        while (n_starts == s0 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_start: no alu_start within %0d cycles", n);
        end
    endtask

    task automatic press_only(input logic [1:0] cmd, input logic [7:0] data);
        @(negedge CLOCK_50);
        sw_cmd  = cmd;
        sw_data = data;
        enter_n = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        enter_n = 1'b1;
    endtask

    task automatic press(input logic [1:0] cmd, input logic [7:0] data);
        press_only(cmd, data);
        wait_idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth: got %0d expected 0", depth); end
        checks++; if (top !== 8'h00) begin errors++; $display("FAIL reset_top: got %h expected 00", top); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b expected 0", err_underflow); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_of: got %b expected 0", err_overflow); end
        checks++; if (mem_we !== 1'b0 || n_writes != 0) begin errors++; $display("FAIL reset_we: we=%b writes=%0d expected 0", mem_we, n_writes); end
        checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", alu_start); end
    endtask

    task automatic test_push();
        int w0 = n_writes;
        press(2'b00, 8'h29);
        checks++; if (n_writes - w0 != 1) begin errors++; $display("FAIL push_wcount: got %0d expected 1", n_writes - w0); end
        checks++; if (last_waddr !== 3'd0) begin errors++; $display("FAIL push_addr: got %0d expected 0", last_waddr); end
        checks++; if (last_wdata !== 8'h29) begin errors++; $display("FAIL push_data: got %h expected 29", last_wdata); end
        checks++; if (depth !== 4'd1) begin errors++; $display("FAIL push_depth: got %0d expected 1", depth); end
        checks++; if (top !== 8'h29) begin errors++; $display("FAIL push_top: got %h expected 29", top); end
    endtask

    task automatic test_add();
        int w0, s0;
        do_reset();
        press(2'b00, 8'h29);
        press(2'b00, 8'hFF);
        w0 = n_writes;
        s0 = n_starts;
        press(2'b01, 8'h00);
        checks++; if (n_starts - s0 != 1) begin errors++; $display("FAIL add_starts: got %0d expected 1", n_starts - s0); end
        checks++; if (st_a !== 8'h29) begin errors++; $display("FAIL add_a: got %h expected 29", st_a); end
        checks++; if (st_b !== 8'hFF) begin errors++; $display("FAIL add_b: got %h expected ff", st_b); end
        checks++; if (st_op !== 2'b01) begin errors++; $display("FAIL add_op: got %b expected 01", st_op); end
        checks++; if (n_writes - w0 != 1) begin errors++; $display("FAIL add_wcount: got %0d expected 1", n_writes - w0); end
        checks++; if (last_waddr !== 3'd0) begin errors++; $display("FAIL add_waddr: got %0d expected 0", last_waddr); end
        checks++; if (last_wdata !== 8'h28) begin errors++; $display("FAIL add_wdata: got %h expected 28", last_wdata); end
        checks++; if (depth !== 4'd1) begin errors++; $display("FAIL add_depth: got %0d expected 1", depth); end
        checks++; if (top !== 8'h28) begin errors++; $display("FAIL add_top: got %h expected 28", top); end
    endtask

    task automatic test_underflow();
        int w0 = n_writes;
        int s0 = n_starts;
        press(2'b01, 8'h00);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %b expected 1", err_underflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uf_busy: got %b expected 0", busy); end
        checks++; if (n_writes != w0 || n_starts != s0) begin errors++; $display("FAIL uf_activity: writes+%0d starts+%0d expected 0", n_writes - w0, n_starts - s0); end
        checks++; if (depth !== 4'd1 || top !== 8'h28) begin errors++; $display("FAIL uf_state: depth=%0d top=%h expected 1/28", depth, top); end
        press(2'b00, 8'h05);
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", err_underflow); end
        checks++; if (depth !== 4'd2 || top !== 8'h05) begin errors++; $display("FAIL uf_push: depth=%0d top=%h expected 2/05", depth, top); end
    endtask

    task automatic test_overflow();
        int w0;
        do_reset();
        for (int i = 0; i < 8; i++) press(2'b00, 8'(i + 1));
        checks++; if (last_waddr !== 3'd7 || last_wdata !== 8'h08) begin errors++; $display("FAIL of_eighth: addr=%0d data=%h expected 7/08", last_waddr, last_wdata); end
        checks++; if (depth !== 4'd8) begin errors++; $display("FAIL of_full: got %0d expected 8", depth); end
        w0 = n_writes;
        press(2'b00, 8'h99);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL of_flag: got %b expected 1", err_overflow); end
        checks++; if (depth !== 4'd8) begin errors++; $display("FAIL of_depth: got %0d expected 8", depth); end
        checks++; if (n_writes != w0) begin errors++; $display("FAIL of_nowrite: got %0d writes expected 0", n_writes - w0); end
        checks++; if (top !== 8'h08) begin errors++; $display("FAIL of_top: got %h expected 08", top); end
    endtask

    task automatic test_sub_mul();
        press(2'b10, 8'h00);
        checks++; if (st_a !== 8'h07 || st_b !== 8'h08) begin errors++; $display("FAIL sub_ops: a=%h b=%h expected 07/08", st_a, st_b); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL sub_ofclr: got %b expected 0", err_overflow); end
        checks++; if (depth !== 4'd7 || top !== 8'hFF || last_waddr !== 3'd6) begin errors++; $display("FAIL sub_res: depth=%0d top=%h addr=%0d expected 7/ff/6", depth, top, last_waddr); end
        press(2'b11, 8'h00);
        checks++; if (st_a !== 8'h06 || st_b !== 8'hFF || st_op !== 2'b11) begin errors++; $display("FAIL mul_ops: a=%h b=%h op=%b expected 06/ff/11", st_a, st_b, st_op); end
        checks++; if (depth !== 4'd6 || top !== 8'hFA || last_wdata !== 8'hFA) begin errors++; $display("FAIL mul_res: depth=%0d top=%h wdata=%h expected 6/fa/fa", depth, top, last_wdata); end
    endtask

    task automatic test_busy_drop();
        int w0, s0;
        do_reset();
        press(2'b00, 8'h03);
        press(2'b00, 8'h04);
        alu_lat = 20;
        w0 = n_writes;
        s0 = n_starts;
        press_only(2'b11, 8'h00);
        wait_start(s0);
        enter_n = 1'b0;
        repeat (50) @(negedge CLOCK_50);
        enter_n = 1'b1;
        wait_idle();
        repeat (10) @(negedge CLOCK_50);
        checks++; if (n_starts - s0 != 1) begin errors++; $display("FAIL drop_starts: got %0d expected 1", n_starts - s0); end
        checks++; if (n_writes - w0 != 1) begin errors++; $display("FAIL drop_writes: got %0d expected 1", n_writes - w0); end
        checks++; if (depth !== 4'd1 || top !== 8'h0C) begin errors++; $display("FAIL drop_state: depth=%0d top=%h expected 1/0c", depth, top); end
    endtask

    task automatic test_reset_in_wait();
        int w0, s0;
        press(2'b00, 8'h02);
        press(2'b00, 8'h03);
        checks++; if (depth !== 4'd3) begin errors++; $display("FAIL rw_pre: got %0d expected 3", depth); end
        s0 = n_starts;
        press_only(2'b01, 8'h00);
        wait_start(s0);
        repeat (3) @(negedge CLOCK_50);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        w0 = n_writes;
        repeat (40) @(negedge CLOCK_50);
        checks++; if (depth !== 4'd0 || top !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rw_state: depth=%0d top=%h busy=%b expected 0/00/0", depth, top, busy); end
        checks++; if (n_writes != w0) begin errors++; $display("FAIL rw_ignored: got %0d writes expected 0", n_writes - w0); end
        alu_lat = 3;
    endtask

    initial begin
        test_reset();
        test_push();
        test_add();
        test_underflow();
        test_overflow();
        test_sub_mul();
        test_busy_drop();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpn_ctrl.md
Name: rpn_ctrl

Overview:
Sequencing controller for the RPN calculator datapath. Turns debounced-free raw Enter presses plus switch-selected commands into stack-RAM reads and writes and ALU start/done transactions. Owns the stack pointer, cached top-of-stack, and error flags. Sits between the board I/O (KEY/SW) and the stack RAM + ALU; its top/depth/error outputs feed the HEX/LEDR display logic.

Parameters:
W, 8, data/stack word width
AW, 3, stack RAM address width
DEPTH, 8, stack capacity in entries (must be <= 2**AW)

Ports:
CLOCK_50  in  1  system clock
rst_n  in  1  asynchronous active-low reset (board KEY[1])
enter_n  in  1  raw Enter button (KEY[0]), active low, asynchronous to clock
sw_cmd  in  2  command: 00 push, 01 add, 10 sub, 11 mul
sw_data  in  W  push operand (SW[7:0])
mem_addr  out  AW  stack RAM address
mem_wdata  out  W  stack RAM write data
mem_we  out  1  stack RAM write enable
mem_rdata  in  W  stack RAM read data, valid 1 cycle after mem_addr
alu_op  out  2  operation code (= latched sw_cmd)
alu_a  out  W  first operand (deeper entry)
alu_b  out  W  second operand (top entry)
alu_start  out  1  one-cycle start pulse
alu_result  in  W  ALU result, valid with alu_done
alu_done  in  1  one-cycle completion pulse, >=1 cycle after alu_start
top  out  W  current top-of-stack (0 when empty)
depth  out  AW+1  number of stack entries
busy  out  1  high whenever state != IDLE
err_underflow  out  1  sticky: last command had too few operands
err_overflow  out  1  sticky: last push found stack full

Behaviour:
- Clocking/reset: single domain CLOCK_50; rst_n asynchronous assert, active low. Reset: state=IDLE, depth=0, top=0, all outputs 0, sync flops=1 (released). Reset mid-operation aborts; any in-flight ALU result is ignored.
- Enter: 2-flop synchronizer on enter_n, third flop for edge; accept = synced high->low transition. One accept per press; holding the key does nothing further.
- Accept is honoured only in IDLE; accepts while busy are dropped. On accept: latch sw_cmd and sw_data, clear both error flags, then check:
  - push with depth==DEPTH: set err_overflow, stay IDLE, no RAM write.
  - op with depth<2: set err_underflow, stay IDLE, nothing changes.
- States: IDLE, PUSH_WR, RD_B, RD_A, EXEC, WAIT_ALU, WB.
- Push: IDLE(accept) -> PUSH_WR: mem_we=1, mem_addr=depth, mem_wdata=latched data; at that edge depth+1, top=data -> IDLE. Done 1 cycle after accept.
- Binary op: RD_B: mem_addr=depth-1. RD_A: mem_addr=depth-2, capture alu_b<=mem_rdata. EXEC: capture alu_a<=mem_rdata, alu_start=1 next cycle (alu_a/alu_b stable before and during start). WAIT_ALU: hold operands and alu_op; on alu_done -> WB. WB: mem_we=1, mem_addr=depth-2, mem_wdata=latched result; depth-1; top=result -> IDLE.
- alu_done outside WAIT_ALU is ignored. No timeout.
- Arithmetic: ALU result is W bits (wrap is ALU's concern); controller performs no arithmetic beyond depth/address +-1/-2. depth never exceeds DEPTH or goes negative.
- mem_we high only in PUSH_WR and WB; mem_addr=0 when unused.

Decomposition:
- Package rpn_pkg: command encodings (CMD_PUSH/ADD/SUB/MUL), state encoding, default W/AW.
- Sub-module rpn_key_sync: 2-flop synchronizer + falling-edge pulse for enter_n (reusable for other KEYs).

Test Plan:
- Reset then idle: rst_n low 1 cycle -> depth=0, top=0, busy=0, flags 0; no mem_we.
- Push 0x29: sw_cmd=00, sw_data=0x29, enter pulse -> one mem_we at addr 0 data 0x29; depth=1, top=0x29.
- Push 0x29, push 0xFF, add (ALU model returns 0x28 after 3 cycles) -> reads addr1 then addr0, alu_a=0x29, alu_b=0xFF, one alu_start; write 0x28 at addr0; depth=1, top=0x28.
- Add with depth=1 -> err_underflow=1, no RAM/ALU activity, depth/top unchanged; next valid push clears it.
- Nine pushes with DEPTH=8 -> ninth sets err_overflow, depth stays 8, no ninth write.
- Enter pressed during WAIT_ALU and enter_n held low 50 cycles -> dropped, only one command executed; rst_n asserted in WAIT_ALU -> IDLE, depth=0, later alu_done ignored.
